// File: rtl/trace_event_monitor.sv
// trace_event_monitor: decodes l.nop exit/report/putc at the writeback stage of
// several cores, merges them round-robin into one buffered valid/ready stream,
// and tracks per-core and global termination.
module trace_event_monitor #(
    parameter int unsigned CORES      = 1,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned CNT_WIDTH  = 16,
    localparam int unsigned ID_W      = (CORES > 1) ? $clog2(CORES) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CORES-1:0]      enable,
    input  logic [32*CORES-1:0]   wb_insn,
    input  logic [32*CORES-1:0]   r3,
    output logic                  event_valid,
    input  logic                  event_ready,
    output logic [ID_W-1:0]       event_core,
    output logic [1:0]            event_type,
    output logic [31:0]           event_value,
    output logic [CORES-1:0]      termination,
    output logic                  termination_all,
    output logic [CNT_WIDTH-1:0]  overflow_cnt
);

    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned FCNT_W = PTR_W + 1;
    localparam int unsigned DROP_W = 5;

    typedef struct packed {
        logic [ID_W-1:0] core;
        logic [1:0]      kind;
        logic [31:0]     value;
    } rec_t;

    logic [CORES-1:0]     dec_valid, dec_exit;
    logic [1:0]           dec_type  [CORES];
    logic [31:0]          dec_value [CORES];

    logic [CORES-1:0]     slot_valid, slot_valid_n;
    logic [1:0]           slot_type   [CORES];
    logic [1:0]           slot_type_n [CORES];
    logic [31:0]          slot_value   [CORES];
    logic [31:0]          slot_value_n [CORES];

    logic [ID_W-1:0]      rr_ptr, rr_ptr_n;
    logic [ID_W-1:0]      grant_idx;
    logic                 grant_any;
    logic [CORES-1:0]     grant;
    int unsigned          idx;

    logic [DROP_W-1:0]    drops;
    logic [CNT_WIDTH:0]   ovf_sum;
    logic [CNT_WIDTH-1:0] ovf_n;

    rec_t                 mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
    logic [FCNT_W-1:0]    fifo_cnt, fifo_cnt_n;
    logic                 pop, can_grant;
    rec_t                 push_rec, head_rec;

    // Per-core decode of the magic l.nop instructions
    always_comb begin
        for (int unsigned c = 0; c < CORES; c++) begin
            dec_valid[c] = 1'b0;
            dec_exit[c]  = 1'b0;
            dec_type[c]  = 2'd0;
            dec_value[c] = r3[32*c +: 32];
            if (enable[c] && wb_insn[32*c+24 +: 8] == 8'h15) begin
                case (wb_insn[32*c +: 16])
                    16'h0001: begin
                        dec_valid[c] = 1'b1;
                        dec_exit[c]  = 1'b1;
                        dec_type[c]  = 2'd2;
                    end
                    16'h0002: begin
                        dec_valid[c] = 1'b1;
                        dec_type[c]  = 2'd1;
                    end
                    16'h0004: begin
                        dec_valid[c] = 1'b1;
                        dec_type[c]  = 2'd0;
                        dec_value[c] = {24'h0, r3[32*c +: 8]};
                    end
                    default: ;
                endcase
            end
        end
    end

    // Round-robin grant of one valid slot when the FIFO can take it
    always_comb begin
        pop       = event_valid & event_ready;
        can_grant = (fifo_cnt != FCNT_W'(FIFO_DEPTH)) || pop;
        grant_any = 1'b0;
        grant_idx = '0;
        idx       = 0;
        for (int unsigned i = 0; i < CORES; i++) begin
            idx = (32'(rr_ptr) + i) % CORES;
            if (!grant_any && can_grant && slot_valid[idx]) begin
                grant_any = 1'b1;
                grant_idx = ID_W'(idx);
            end
        end
        for (int unsigned c = 0; c < CORES; c++) begin
            grant[c] = grant_any && (grant_idx == ID_W'(c));
        end
        if (!grant_any) begin
            rr_ptr_n = rr_ptr;
        end else if (grant_idx == ID_W'(CORES - 1)) begin
            rr_ptr_n = '0;
        end else begin
            rr_ptr_n = grant_idx + ID_W'(1);
        end
        push_rec = '{core: grant_idx, kind: slot_type[grant_idx], value: slot_value[grant_idx]};
    end

    // Capture slot update and overflow accounting
    always_comb begin
        drops = '0;
        for (int unsigned c = 0; c < CORES; c++) begin
            slot_valid_n[c] = slot_valid[c] & ~grant[c];
            slot_type_n[c]  = slot_type[c];
            slot_value_n[c] = slot_value[c];
            if (dec_valid[c]) begin
                if (!slot_valid[c] || grant[c]) begin
                    slot_valid_n[c] = 1'b1;
                    slot_type_n[c]  = dec_type[c];
                    slot_value_n[c] = dec_value[c];
                end else begin
                    drops = drops + DROP_W'(1);
                end
            end
        end
        ovf_sum = {1'b0, overflow_cnt} + (CNT_WIDTH+1)'(drops);
        ovf_n   = ovf_sum[CNT_WIDTH] ? '1 : ovf_sum[CNT_WIDTH-1:0];
    end

    // FIFO pointers and the next head; a push into the head slot bypasses the array
    always_comb begin
        wr_ptr_n   = grant_any ? wr_ptr + PTR_W'(1) : wr_ptr;
        rd_ptr_n   = pop ? rd_ptr + PTR_W'(1) : rd_ptr;
        fifo_cnt_n = fifo_cnt + FCNT_W'(grant_any) - FCNT_W'(pop);
        if (grant_any && rd_ptr_n == wr_ptr) begin
            head_rec = push_rec;
        end else begin
            head_rec = mem[rd_ptr_n];
        end
    end

    // FIFO storage array
    always_ff @(posedge clk) begin
        if (grant_any) begin
            mem[wr_ptr] <= push_rec;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_valid      <= '0;
            for (int unsigned c = 0; c < CORES; c++) begin
                slot_type[c]  <= 2'd0;
                slot_value[c] <= 32'd0;
            end
            rr_ptr          <= '0;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            fifo_cnt        <= '0;
            event_valid     <= 1'b0;
            event_core      <= '0;
            event_type      <= 2'd0;
            event_value     <= 32'd0;
            termination     <= '0;
            termination_all <= 1'b0;
            overflow_cnt    <= '0;
        end else begin
            slot_valid      <= slot_valid_n;
            for (int unsigned c = 0; c < CORES; c++) begin
                slot_type[c]  <= slot_type_n[c];
                slot_value[c] <= slot_value_n[c];
            end
            rr_ptr          <= rr_ptr_n;
            wr_ptr          <= wr_ptr_n;
            rd_ptr          <= rd_ptr_n;
            fifo_cnt        <= fifo_cnt_n;
            event_valid     <= (fifo_cnt_n != '0);
            if (fifo_cnt_n != '0) begin
                event_core  <= head_rec.core;
                event_type  <= head_rec.kind;
                event_value <= head_rec.value;
            end
            termination     <= termination | dec_exit;
            termination_all <= &termination;
            overflow_cnt    <= ovf_n;
        end
    end

endmodule

// File: tb/tb_trace_event_monitor.sv
// Scoreboard bench for trace_event_monitor with four cores and a four-entry FIFO.
module tb_trace_event_monitor;

    localparam int unsigned CORES = 4;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = 16;
    localparam int unsigned ID_W  = 2;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [CORES-1:0]     enable = '0;
    logic [32*CORES-1:0]  wb_insn = '0;
    logic [32*CORES-1:0]  r3 = '0;
    logic                 event_ready = 1'b0;
    logic                 event_valid;
    logic [ID_W-1:0]      event_core;
    logic [1:0]           event_type;
    logic [31:0]          event_value;
    logic [CORES-1:0]     termination;
    logic                 termination_all;
    logic [CW-1:0]        overflow_cnt;

    trace_event_monitor #(.CORES(CORES), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .enable(enable), .wb_insn(wb_insn), .r3(r3),
        .event_valid(event_valid), .event_ready(event_ready),
        .event_core(event_core), .event_type(event_type), .event_value(event_value),
        .termination(termination), .termination_all(termination_all),
        .overflow_cnt(overflow_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ID_W-1:0] core;
        logic [1:0]      kind;
        logic [31:0]     value;
    } rec_t;

    rec_t exp_q[$];
    rec_t mon_e;
    int   n_vec = 0;
    int   n_err = 0;

    function automatic rec_t mk(input int c, input int k, input logic [31:0] v);
        rec_t r;
        r.core  = ID_W'(c);
        r.kind  = 2'(k);
        r.value = v;
        return r;
    endfunction

    function automatic logic [31:0] nop(input logic [15:0] k);
        return {8'h15, 8'h00, k};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input int c, input logic [31:0] insn, input logic [31:0] v);
        enable[c]         = 1'b1;
        wb_insn[32*c +: 32] = insn;
        r3[32*c +: 32]      = v;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        enable = '0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(posedge clk);
            t++;
        end
        #1;
        check(name, 32'(exp_q.size()), 32'd0);
        cycles(3);
    endtask

    initial begin
        #1;
        check("rst_valid", 32'(event_valid), 32'd0);
        check("rst_value", event_value, 32'd0);
        check("rst_term", 32'(termination), 32'd0);
        check("rst_ovf", 32'(overflow_cnt), 32'd0);
        cycles(2);
        rst = 1'b0;

        // Monitor: pop and compare each transferred record
        fork
            forever begin
                @(negedge clk);
                if (!rst && event_valid && event_ready) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_record: got core %0d type %0d value %h, expected none",
                                 event_core, event_type, event_value);
                    end else begin
                        mon_e = exp_q.pop_front();
                        check("rec_core", 32'(event_core), 32'(mon_e.core));
                        check("rec_type", 32'(event_type), 32'(mon_e.kind));
                        check("rec_value", event_value, mon_e.value);
                    end
                end
            end
        join_none

        // Single putc, minimum latency
        event_ready = 1'b1;
        drive(0, nop(16'h0004), 32'h0000_0141);
        exp_q.push_back(mk(0, 0, 32'h41));
        tick();
        @(negedge clk);
        check("lat_early", 32'(event_valid), 32'd0);
        @(negedge clk);
        check("lat_two", 32'(event_valid), 32'd1);
        wait_drain("putc_drain");
        check("putc_ovf", 32'(overflow_cnt), 32'd0);

        // Four simultaneous reports leave in core order on consecutive cycles
        do_reset();
        for (int c = 0; c < 4; c++) begin
            drive(c, nop(16'h0002), 32'(c));
            exp_q.push_back(mk(c, 1, 32'(c)));
        end
        tick();
        begin
            int t;
            t = 0;
            @(negedge clk);
            while (!event_valid && t < 10) begin
                @(negedge clk);
                t++;
            end
            for (int k = 0; k < 4; k++) begin
                check("rr_consecutive", 32'(event_valid), 32'd1);
                @(negedge clk);
            end
            check("rr_idle", 32'(event_valid), 32'd0);
        end
        wait_drain("rr_drain");
        check("rr_ovf", 32'(overflow_cnt), 32'd0);

        // Back-pressure: 4 in FIFO, 1 in slot, 2 dropped
        do_reset();
        event_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            drive(0, nop(16'h0002), 32'h100 + 32'(i));
            if (i < 5) exp_q.push_back(mk(0, 1, 32'h100 + 32'(i)));
            tick();
        end
        check("bp_ovf", 32'(overflow_cnt), 32'd2);
        check("bp_valid", 32'(event_valid), 32'd1);
        cycles(3);
        check("bp_hold_value", event_value, 32'h100);
        check("bp_hold_valid", 32'(event_valid), 32'd1);
        event_ready = 1'b1;
        wait_drain("bp_drain");
        check("bp_ovf_after", 32'(overflow_cnt), 32'd2);

        // Termination tracking, including an exit dropped on a full FIFO
        do_reset();
        event_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            cycles(9);
            drive(c, nop(16'h0001), 32'hE0 + 32'(c));
            exp_q.push_back(mk(c, 2, 32'hE0 + 32'(c)));
            tick();
            check("term_step", 32'(termination), 32'((1 << (c + 1)) - 1));
        end
        cycles(5);
        check("term_all_low", 32'(termination_all), 32'd0);
        event_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(3, nop(16'h0002), 32'h300 + 32'(i));
            exp_q.push_back(mk(3, 1, 32'h300 + 32'(i)));
            tick();
        end
        drive(3, nop(16'h0001), 32'h3E);
        tick();
        check("term_blocked", 32'(termination), 32'hF);
        check("term_all_lag", 32'(termination_all), 32'd0);
        cycles(1);
        check("term_all_rise", 32'(termination_all), 32'd1);
        check("term_ovf", 32'(overflow_cnt), 32'd1);
        event_ready = 1'b1;
        wait_drain("term_drain");
        drive(0, nop(16'h0001), 32'hE1);
        exp_q.push_back(mk(0, 2, 32'hE1));
        tick();
        check("term_repeat", 32'(termination), 32'hF);
        wait_drain("repeat_drain");

        // Non-event traffic produces nothing
        do_reset();
        event_ready = 1'b1;
        drive(0, nop(16'h0003), 32'h1);
        wb_insn[63:32] = nop(16'h0001);
        drive(2, 32'h9C60_0001, 32'h5);
        tick();
        cycles(8);
        check("quiet_valid", 32'(event_valid), 32'd0);
        check("quiet_term", 32'(termination), 32'd0);
        check("quiet_ovf", 32'(overflow_cnt), 32'd0);

        // Asynchronous reset with records buffered
        do_reset();
        event_ready = 1'b0;
        drive(0, nop(16'h0004), 32'h41);
        drive(1, nop(16'h0004), 32'h42);
        drive(2, nop(16'h0004), 32'h43);
        tick();
        cycles(5);
        check("pre_rst_valid", 32'(event_valid), 32'd1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_valid", 32'(event_valid), 32'd0);
        check("async_value", event_value, 32'd0);
        check("async_core", 32'(event_core), 32'd0);
        check("async_ovf", 32'(overflow_cnt), 32'd0);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_valid", 32'(event_valid), 32'd0);
        event_ready = 1'b1;
        #1;
        drive(2, nop(16'h0004), 32'h0000_015A);
        exp_q.push_back(mk(2, 0, 32'h5A));
        tick();
        wait_drain("post_rst_drain");
        check("post_rst_ovf", 32'(overflow_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
